serial_receiver: RTL and testbench

- Receive end of the calculator's serial transmit link.
- Accepts the serial bitstream, bit clock and frame-valid produced by the calculator top (DataOut, ClkTx, DoutValid) and rebuilds the 32-bit concatenated result word.
- Splits the word into operand A, operand B, ALU result, selector and flags, and presents it with a valid/acknowledge handshake.
- Sits on the host/test side of the link, in the system clock domain; ClkTx is treated as a data signal, never as a clock.

---
 rtl/serial_receiver.sv | 166 ++++++++++++++++
 tb/tb_serial_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// Receive end of the calculator serial link: resynchronises the transmitter's
// bit clock, frame-valid and data, rebuilds the 32-bit word and splits it into fields.
module serial_receiver #(
  parameter int DataSize   = 32,
  parameter int SyncStages = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                SerClk,
  input  logic                SerValid,
  input  logic                SerData,
  input  logic                RxAck,
  output logic [DataSize-1:0] RxWord,
  output logic [7:0]          RxA,
  output logic [7:0]          RxB,
  output logic [7:0]          RxAluOut,
  output logic [3:0]          RxSel,
  output logic [3:0]          RxFlags,
  output logic                RxValid,
  output logic                RxBusy,
  output logic                FrameError,
  output logic                Overrun,
  output logic [1:0]          DbgState
);

  localparam int CntW = $clog2(DataSize) + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECEIVE  = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_END = 2'd3
  } state_t;

  // Handshake: RxValid rises when a word is loaded and holds until a cycle
  // with RxAck==1 (cleared on the following edge); a load in that same cycle wins.

  logic [SyncStages-1:0] r_sclk_sync;
  logic [SyncStages-1:0] r_valid_sync;
  logic [SyncStages-1:0] r_data_sync;
  logic                  r_sclk_prev;

  state_t                r_state;
  state_t                w_state_next;
  logic [CntW-1:0]       r_bit_cnt;
  logic [CntW-1:0]       w_cnt_next;
  logic [DataSize-1:0]   r_shift;
  logic [DataSize-1:0]   w_shift_next;
  logic [DataSize-1:0]   w_shift_in;
  logic [DataSize-1:0]   r_rx_word;
  logic                  r_rx_valid;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  w_frame_err;
  logic                  w_overrun;

  logic                  w_sclk_s;
  logic                  w_valid_s;
  logic                  w_data_s;
  logic                  w_sclk_rise;

  // All three link signals go through identical chains so they stay aligned.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_sclk_sync  <= '0;
      r_valid_sync <= '0;
      r_data_sync  <= '0;
      r_sclk_prev  <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SyncStages-2:0], SerClk};
      r_valid_sync <= {r_valid_sync[SyncStages-2:0], SerValid};
      r_data_sync  <= {r_data_sync[SyncStages-2:0], SerData};
      r_sclk_prev  <= r_sclk_sync[SyncStages-1];
    end
  end

  assign w_sclk_s    = r_sclk_sync[SyncStages-1];
  assign w_valid_s   = r_valid_sync[SyncStages-1];
  assign w_data_s    = r_data_sync[SyncStages-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_shift_in  = {r_shift[DataSize-2:0], w_data_s};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_frame_err  = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid_s) begin
          w_state_next = ST_RECEIVE;
          w_cnt_next   = '0;
          if (w_sclk_rise) begin
            w_shift_next = w_shift_in;
            w_cnt_next   = CntW'(1);
          end
        end
      end
      ST_RECEIVE: begin
        // Valid dropping takes priority over a coincident bit edge.
        if (!w_valid_s) begin
          w_frame_err  = 1'b1;
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_shift_next = '0;
        end else if (w_sclk_rise) begin
          w_shift_next = w_shift_in;
          w_cnt_next   = r_bit_cnt + CntW'(1);
          if (r_bit_cnt == CntW'(DataSize - 1)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_overrun    = r_rx_valid & ~RxAck;
        w_state_next = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (!w_valid_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_word   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_cnt_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
      if (r_state == ST_DONE) begin
        r_rx_word  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (RxAck) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign RxWord     = r_rx_word;
  assign RxA        = r_rx_word[31:24];
  assign RxB        = r_rx_word[23:16];
  assign RxAluOut   = r_rx_word[15:8];
  assign RxSel      = r_rx_word[7:4];
  assign RxFlags    = r_rx_word[3:0];
  assign RxValid    = r_rx_valid;
  assign RxBusy     = (r_state == ST_RECEIVE);
  assign FrameError = r_frame_err;
  assign Overrun    = r_overrun;
  assign DbgState   = r_state;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: frames sent MSB first with an 8-cycle
// bit clock; pulse outputs are tallied by monitors and compared to hand values.
module tb_serial_receiver;

  logic        clk;
  logic        reset;
  logic        ser_clk;
  logic        ser_valid;
  logic        ser_data;
  logic        rx_ack;
  logic [31:0] rx_word;
  logic [7:0]  rx_a;
  logic [7:0]  rx_b;
  logic [7:0]  rx_alu_out;
  logic [3:0]  rx_sel;
  logic [3:0]  rx_flags;
  logic        rx_valid;
  logic        rx_busy;
  logic        frame_error;
  logic        overrun;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  serial_receiver #(.DataSize(32), .SyncStages(2)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .SerClk     (ser_clk),
    .SerValid   (ser_valid),
    .SerData    (ser_data),
    .RxAck      (rx_ack),
    .RxWord     (rx_word),
    .RxA        (rx_a),
    .RxB        (rx_b),
    .RxAluOut   (rx_alu_out),
    .RxSel      (rx_sel),
    .RxFlags    (rx_flags),
    .RxValid    (rx_valid),
    .RxBusy     (rx_busy),
    .FrameError (frame_error),
    .Overrun    (overrun),
    .DbgState   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic frame_start();
    ser_valid = 1'b1;
    ser_clk   = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end();
    ser_clk = 1'b0;
    repeat (4) tick();
    ser_valid = 1'b0;
    repeat (8) tick();
  endtask

  task automatic send_bits(input logic [31:0] w, input int from_bit, input int n_bits,
                           input bit ack_at_done);
    bit acked;
    acked = 1'b0;
    for (int i = 0; i < n_bits; i++) begin
      ser_data = w[31 - (from_bit + i)];
      ser_clk  = 1'b0;
      repeat (4) tick();
      ser_clk = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (ack_at_done && !acked && !rx_busy && (i == n_bits - 1)) begin
          rx_ack = 1'b1;
          tick();
          rx_ack = 1'b0;
          acked  = 1'b1;
        end
      end
    end
    ser_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input bit ack_at_done);
    frame_start();
    send_bits(w, 0, 32, ack_at_done);
    frame_end();
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  initial begin
    int fe_base;
    int ov_base;
    bit stable;
    reset     = 1'b0;
    ser_clk   = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    rx_ack    = 1'b0;
    repeat (3) tick();

    check("rst_word", rx_word, 32'h0);
    check("rst_valid", {31'b0, rx_valid}, 32'h0);
    check("rst_busy", {31'b0, rx_busy}, 32'h0);
    check("rst_ferr", {31'b0, frame_error}, 32'h0);
    check("rst_ovr", {31'b0, overrun}, 32'h0);

    reset = 1'b1;
    repeat (2) tick();

    // Basic frame
    frame_start();
    send_bits(32'h0A050F00, 0, 16, 1'b0);
    check("basic_busy_mid", {31'b0, rx_busy}, 32'h1);
    check("basic_valid_mid", {31'b0, rx_valid}, 32'h0);
    send_bits(32'h0A050F00, 16, 16, 1'b0);
    frame_end();
    check("basic_valid", {31'b0, rx_valid}, 32'h1);
    check("basic_word", rx_word, 32'h0A050F00);
    check("basic_a", {24'b0, rx_a}, 32'h0A);
    check("basic_b", {24'b0, rx_b}, 32'h05);
    check("basic_alu", {24'b0, rx_alu_out}, 32'h0F);
    check("basic_sel", {28'b0, rx_sel}, 32'h0);
    check("basic_flags", {28'b0, rx_flags}, 32'h0);
    check("basic_busy_end", {31'b0, rx_busy}, 32'h0);

    // Handshake
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_valid !== 1'b1 || rx_word !== 32'h0A050F00) stable = 1'b0;
    end
    check("hold_stable", {31'b0, stable}, 32'h1);
    pulse_ack();
    check("ack_valid", {31'b0, rx_valid}, 32'h0);
    check("ack_word", rx_word, 32'h0A050F00);
    pulse_ack();
    check("idle_ack_valid", {31'b0, rx_valid}, 32'h0);
    check("idle_ack_word", rx_word, 32'h0A050F00);

    // Overrun
    ov_base = ov_cnt;
    send_frame(32'h12345606, 1'b0);
    check("ovr_first_word", rx_word, 32'h12345606);
    check("ovr_none_yet", ov_cnt - ov_base, 0);
    send_frame(32'hFFFF0FFE, 1'b0);
    check("ovr_count", ov_cnt - ov_base, 1);
    check("ovr_word", rx_word, 32'hFFFF0FFE);
    check("ovr_flags", {28'b0, rx_flags}, 32'hE);
    check("ovr_valid", {31'b0, rx_valid}, 32'h1);

    // Ack collision with DONE
    ov_base = ov_cnt;
    send_frame(32'h3C4D5E6F, 1'b1);
    check("coll_valid", {31'b0, rx_valid}, 32'h1);
    check("coll_ovr", ov_cnt - ov_base, 0);
    check("coll_word", rx_word, 32'h3C4D5E6F);

    // Short frame
    fe_base = fe_cnt;
    frame_start();
    send_bits(32'hDEADBEEF, 0, 17, 1'b0);
    frame_end();
    check("short_ferr", fe_cnt - fe_base, 1);
    check("short_valid", {31'b0, rx_valid}, 32'h1);
    check("short_word", rx_word, 32'h3C4D5E6F);
    check("short_busy", {31'b0, rx_busy}, 32'h0);
    pulse_ack();
    ov_base = ov_cnt;
    send_frame(32'h80000001, 1'b0);
    check("after_short_word", rx_word, 32'h80000001);
    check("after_short_valid", {31'b0, rx_valid}, 32'h1);
    check("after_short_ferr", fe_cnt - fe_base, 1);
    check("after_short_ovr", ov_cnt - ov_base, 0);

    // Reset mid-frame
    fe_base = fe_cnt;
    frame_start();
    send_bits(32'h5A5A5A5A, 0, 10, 1'b0);
    reset     = 1'b0;
    ser_valid = 1'b0;
    ser_clk   = 1'b0;
    repeat (2) tick();
    check("mrst_word", rx_word, 32'h0);
    check("mrst_valid", {31'b0, rx_valid}, 32'h0);
    check("mrst_busy", {31'b0, rx_busy}, 32'h0);
    check("mrst_ferr", {31'b0, frame_error}, 32'h0);
    check("mrst_ovr", {31'b0, overrun}, 32'h0);
    reset = 1'b1;
    repeat (4) tick();
    send_frame(32'hA5A5A5A5, 1'b0);
    check("mrst_next_word", rx_word, 32'hA5A5A5A5);
    check("mrst_next_valid", {31'b0, rx_valid}, 32'h1);
    check("mrst_no_ferr", fe_cnt - fe_base, 0);

    // SerValid already high when reset releases, then dropped with no bits
    pulse_ack();
    fe_base   = fe_cnt;
    reset     = 1'b0;
    ser_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    check("rel_busy", {31'b0, rx_busy}, 32'h1);
    ser_valid = 1'b0;
    repeat (8) tick();
    check("rel_ferr", fe_cnt - fe_base, 1);
    check("rel_valid", {31'b0, rx_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
